// File: rtl/lipsi_pkg.sv
// Shared definitions for the Lipsi program loader: loader FSM encoding,
// the default frame header byte and the modulo-256 checksum helper.
// Ports: none (package).
package lipsi_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Kept as a function so the sum is truncated to 8 bits before any compare.
  function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/lipsi_uart_rx.sv
// 8N1 UART receiver with two-flop synchronizer, mid-bit sampling and start-bit re-check.
// Latency: byte_valid/frame_err pulse one cycle after the mid-stop-bit sample; no backpressure (pulses are not held).
// Ports: clk, reset (async, active-high), rx (idle high) -> byte_valid, byte_data, frame_err.
module lipsi_uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;

  assign byte_data = shreg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        // Only a genuine high-to-low transition starts a byte, so a line
        // left low after a bad stop bit cannot retrigger.
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rx_sync) begin
              state   <= RX_DATA;
              bit_idx <= '0;
            end else begin
              state <= RX_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lipsi_program_loader.sv
// UART program loader: frame = SYNC, N, N data bytes, checksum; writes bytes to imem 0..N-1.
// Latency: imem_we asserted one cycle after each data byte's byte_valid; no backpressure (memory must accept every strobe).
// Ports: clk, reset (async, active-high), rx -> imem_we/imem_addr/imem_wdata, cpu_hold, load_done, load_error.
module lipsi_program_loader
  import lipsi_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       imem_we,
  output logic [7:0] imem_addr,
  output logic [7:0] imem_wdata,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       load_error
);

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          frame_err;

  loader_state_t state;
  logic [7:0]    len;
  logic [7:0]    cnt;
  logic [7:0]    acc;

  lipsi_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      len        <= '0;
      cnt        <= '0;
      acc        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (frame_err && (state inside {LEN, DATA, CHK})) begin
        state      <= ERR;
        load_done  <= 1'b0;
        load_error <= 1'b1;
      end else if (byte_valid) begin
        case (state)
          IDLE, DONE, ERR: begin
            if (byte_data == SYNC_BYTE) begin
              state      <= LEN;
              cpu_hold   <= 1'b1;
              load_done  <= 1'b0;
              load_error <= 1'b0;
            end
          end
          LEN: begin
            if (byte_data == 8'd0) begin
              state      <= ERR;
              load_error <= 1'b1;
            end else begin
              len   <= byte_data;
              cnt   <= '0;
              acc   <= '0;
              state <= DATA;
            end
          end
          DATA: begin
            imem_we    <= 1'b1;
            imem_addr  <= cnt;
            imem_wdata <= byte_data;
            cnt        <= cnt + 8'd1;
            acc        <= csum_add(acc, byte_data);
            // Widened compare: cnt+1 reaches 255 when N=255.
            if ({1'b0, cnt} + 9'd1 == {1'b0, len}) begin
              state <= CHK;
            end
          end
          CHK: begin
            if (csum_add(acc, byte_data) == 8'd0) begin
              state     <= DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state      <= ERR;
              load_error <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lipsi_program_loader.sv
// Bench for lipsi_program_loader: directed UART frames, write scoreboard, status checks.
module tb_lipsi_program_loader;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [7:0] imem_wdata;
  logic       cpu_hold;
  logic       load_done;
  logic       load_error;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  logic        prev_we = 1'b0;

  always #5 clk = ~clk;

  lipsi_program_loader #(
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_error(load_error)
  );

  // Monitor: every write strobe pops one expected (addr,data) pair.
  always @(negedge clk) begin
    if (reset) begin
      prev_we = 1'b0;
    end else begin
      if (prev_we) begin
        checks++;
        if (imem_we) begin
          failures++;
          $display("FAIL we_pulse_width imem_we=%0b required=0 (strobe longer than 1 cycle)", imem_we);
        end
      end
      if (imem_we && !prev_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write actual addr=%02h data=%02h required=no write", imem_addr, imem_wdata);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({imem_addr, imem_wdata} !== mon_exp) begin
            failures++;
            $display("FAIL write actual addr=%02h data=%02h required addr=%02h data=%02h",
                     imem_addr, imem_wdata, mon_exp[15:8], mon_exp[7:0]);
          end
        end
      end
      prev_we = imem_we;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_w(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic sb(input logic [7:0] b);
    send_byte(b, 1'b1);
  endtask

  task automatic status(input string tag, input logic done, input logic err, input logic hold);
    chk({tag, "_load_done"}, 32'(load_done), 32'(done));
    chk({tag, "_load_error"}, 32'(load_error), 32'(err));
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(hold));
    chk({tag, "_writes_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'h00);
    chk("rst_imem_wdata", 32'(imem_wdata), 32'h00);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_error", 32'(load_error), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Good 3-byte frame; checksum C7+0F+FF+2B = 0x200.
    push_w(8'h00, 8'hC7); push_w(8'h01, 8'h0F); push_w(8'h02, 8'hFF);
    sb(8'hA5); sb(8'h03); sb(8'hC7); sb(8'h0F); sb(8'hFF); sb(8'h2B);
    status("frame_good", 1'b1, 1'b0, 1'b0);
    chk("hold_addr", 32'(imem_addr), 32'h02);
    chk("hold_wdata", 32'(imem_wdata), 32'hFF);

    // SYNC accepted in DONE raises cpu_hold; bad checksum 11+22+00 -> ERR.
    sb(8'hA5);
    chk("sync_in_done_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("sync_in_done_load_done", 32'(load_done), 32'd0);
    push_w(8'h00, 8'h11); push_w(8'h01, 8'h22);
    sb(8'h02); sb(8'h11); sb(8'h22); sb(8'h00);
    status("bad_csum", 1'b0, 1'b1, 1'b1);

    // Zero length -> ERR, then recovery with a 1-byte frame.
    sb(8'hA5); sb(8'h00);
    status("zero_len", 1'b0, 1'b1, 1'b1);
    push_w(8'h00, 8'hFF);
    sb(8'hA5); sb(8'h01); sb(8'hFF); sb(8'h01);
    status("recover", 1'b1, 1'b0, 1'b0);

    // Noise before SYNC is ignored while in DONE.
    sb(8'h3C); sb(8'h55);
    status("noise", 1'b1, 1'b0, 1'b0);
    push_w(8'h00, 8'h07);
    sb(8'hA5); sb(8'h01); sb(8'h07); sb(8'hF9);
    status("after_noise", 1'b1, 1'b0, 1'b0);

    // Low stop bit in DATA -> ERR without a write.
    sb(8'hA5); sb(8'h02);
    send_byte(8'h5A, 1'b0);
    status("stop_low", 1'b0, 1'b1, 1'b1);

    // One-bit-time low pulse on the idle line: whatever the UART makes of it is not SYNC.
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    status("bit_glitch", 1'b0, 1'b1, 1'b1);
    // Short glitch fails the mid-start re-check; following frame must frame correctly.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    push_w(8'h00, 8'h07);
    sb(8'hA5); sb(8'h01); sb(8'h07); sb(8'hF9);
    status("after_glitch", 1'b1, 1'b0, 1'b0);

    // Reset after the second data byte of a 4-byte frame.
    push_w(8'h00, 8'h10); push_w(8'h01, 8'h20);
    sb(8'hA5); sb(8'h04); sb(8'h10); sb(8'h20);
    #2 reset = 1'b1;
    #1;
    chk("midrst_imem_we", 32'(imem_we), 32'd0);
    chk("midrst_imem_addr", 32'(imem_addr), 32'h00);
    chk("midrst_imem_wdata", 32'(imem_wdata), 32'h00);
    chk("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("midrst_load_done", 32'(load_done), 32'd0);
    chk("midrst_load_error", 32'(load_error), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    // Remaining bytes of the aborted frame land in IDLE and are ignored.
    sb(8'h30); sb(8'h40); sb(8'h60);
    status("after_reset", 1'b0, 1'b0, 1'b1);
    push_w(8'h00, 8'hFF);
    sb(8'hA5); sb(8'h01); sb(8'hFF); sb(8'h01);
    status("reload", 1'b1, 1'b0, 1'b0);

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
